// File: rtl/timer_bank.sv
// timer_bank: NCH independent programmable timers, periodic or one-shot,
// each with a registered expiry tick and a sticky done flag.
module timer_bank #(
    parameter int          NCH        = 4,
    parameter int          W          = 24,
    parameter int unsigned DEF_PERIOD = 1200000,
    localparam int         SW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           wr,
    input  logic [SW-1:0]  sel,
    input  logic [1:0]     cmd,
    input  logic [W-1:0]   wdata,
    input  logic [NCH-1:0] clr,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done
);

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_PER   = 2'b01;
    localparam logic [1:0] CMD_ONE   = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;
    localparam logic [W-1:0] DEF_P   = W'(DEF_PERIOD);

    logic [W-1:0]   period_q [NCH];
    logic [W-1:0]   period_d [NCH];
    logic [W-1:0]   pend_q   [NCH];
    logic [W-1:0]   pend_d   [NCH];
    logic [W-1:0]   cnt_q    [NCH];
    logic [W-1:0]   cnt_d    [NCH];
    logic [W-1:0]   p_eff    [NCH];
    logic [NCH-1:0] mode_q, mode_d;
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] done_q, done_d;
    logic [NCH-1:0] hit, expire;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            p_eff[i]  = (period_q[i] == '0) ? W'(1) : period_q[i];
            expire[i] = busy_q[i] && (cnt_q[i] == p_eff[i] - W'(1));
            hit[i]    = wr && (sel == SW'(i));
        end
    end

    // Commands on the same edge override the expiry: LOAD retargets the
    // period, START/STOP cancel the tick and leave done untouched.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            period_d[i] = period_q[i];
            pend_d[i]   = pend_q[i];
            cnt_d[i]    = cnt_q[i];
            mode_d[i]   = mode_q[i];
            busy_d[i]   = busy_q[i];
            tick_d[i]   = 1'b0;
            done_d[i]   = done_q[i] & ~clr[i];
            if (busy_q[i]) begin
                cnt_d[i] = cnt_q[i] + W'(1);
            end
            if (expire[i]) begin
                cnt_d[i]    = '0;
                tick_d[i]   = 1'b1;
                done_d[i]   = 1'b1;
                period_d[i] = pend_q[i];
                if (mode_q[i]) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (hit[i]) begin
                case (cmd)
                    CMD_LOAD: begin
                        pend_d[i] = wdata;
                        if (!busy_q[i] || expire[i]) begin
                            period_d[i] = wdata;
                        end
                    end
                    CMD_PER, CMD_ONE: begin
                        period_d[i] = pend_q[i];
                        cnt_d[i]    = '0;
                        busy_d[i]   = 1'b1;
                        mode_d[i]   = cmd[1];
                        tick_d[i]   = 1'b0;
                        done_d[i]   = done_q[i] & ~clr[i];
                    end
                    CMD_STOP: begin
                        if (busy_q[i]) begin
                            period_d[i] = period_q[i];
                            busy_d[i]   = 1'b0;
                            cnt_d[i]    = '0;
                            tick_d[i]   = 1'b0;
                            done_d[i]   = done_q[i] & ~clr[i];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                period_q[i] <= DEF_P;
                pend_q[i]   <= DEF_P;
                cnt_q[i]    <= '0;
            end
            mode_q <= '0;
            busy_q <= '0;
            tick_q <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                period_q[i] <= period_d[i];
                pend_q[i]   <= pend_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            mode_q <= mode_d;
            busy_q <= busy_d;
            tick_q <= tick_d;
            done_q <= done_d;
        end
    end

    assign tick = tick_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed checks of timer_bank with a short default period
// and one spare channel so that an out-of-range sel can be exercised.
module tb_timer_bank;

    localparam int NCH = 5;
    localparam int W   = 24;
    localparam int SW  = 3;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           wr = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [1:0]     cmd = '0;
    logic [W-1:0]   wdata = '0;
    logic [NCH-1:0] clr = '0;
    logic [NCH-1:0] tick, busy, done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int s [4];

    timer_bank #(.NCH(NCH), .W(W), .DEF_PERIOD(10)) dut (
        .clk(clk), .rstn(rstn), .wr(wr), .sel(sel), .cmd(cmd),
        .wdata(wdata), .clr(clr), .tick(tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cmd_op(input int ch, input logic [1:0] c, input int data);
        wr = 1'b1;
        sel = SW'(ch);
        cmd = c;
        wdata = W'(data);
        step();
        wr = 1'b0;
    endtask

    // Edges stepped until tick[ch] is seen; -1 if the budget expires.
    task automatic wait_tick(input int ch, output int n);
        bit found;
        found = 1'b0;
        n = -1;
        for (int k = 1; k <= 40 && !found; k++) begin
            step();
            if (tick[ch]) begin
                n = k;
                found = 1'b1;
            end
        end
    endtask

    initial begin
        int n;
        int cnt;
        int e;
        int d;
        bit stopped;
        logic [3:0] exp_t;

        repeat (3) step();
        check("rst tick", 32'(tick), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        rstn = 1'b1;
        step();

        // 1: periodic ch0 with default period 10
        cmd_op(0, 2'b01, 0);
        check("t1 busy0", 32'(busy[0]), 1);
        wait_tick(0, n);
        check("t1 first", n, 10);
        wait_tick(0, n);
        check("t1 second", n, 10);
        wait_tick(0, n);
        check("t1 third", n, 10);
        step();
        check("t1 width", 32'(tick[0]), 0);
        cmd_op(0, 2'b11, 0);
        check("t1 stop", 32'(busy[0]), 0);
        check("t1 done0", 32'(done[0]), 1);

        // 2: one-shot ch1, P=5
        cmd_op(1, 2'b00, 5);
        cmd_op(1, 2'b10, 0);
        wait_tick(1, n);
        check("t2 tick", n, 5);
        check("t2 busy1", 32'(busy[1]), 0);
        check("t2 done1", 32'(done[1]), 1);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (tick[1]) cnt++;
        end
        check("t2 no more", cnt, 0);
        check("t2 sticky", 32'(done[1]), 1);
        clr = 5'b00010;
        step();
        clr = '0;
        check("t2 clr", 32'(done[1]), 0);

        // 3: ch2 P=8, LOAD 3 mid-interval, then LOAD 0
        cmd_op(2, 2'b00, 8);
        cmd_op(2, 2'b01, 0);
        repeat (3) step();
        cmd_op(2, 2'b00, 3);
        wait_tick(2, n);
        check("t3 old", n, 4);
        wait_tick(2, n);
        check("t3 new1", n, 3);
        wait_tick(2, n);
        check("t3 new2", n, 3);
        cmd_op(2, 2'b00, 0);
        wait_tick(2, n);
        check("t3 last3", n, 2);
        wait_tick(2, n);
        check("t3 p0 a", n, 1);
        wait_tick(2, n);
        check("t3 p0 b", n, 1);
        cmd_op(2, 2'b11, 0);
        check("t3 stop", 32'(busy[2]), 0);

        // 4: ch3 P=4, STOP then START on the expiry edge
        cmd_op(3, 2'b00, 4);
        cmd_op(3, 2'b01, 0);
        repeat (3) step();
        cmd_op(3, 2'b11, 0);
        check("t4 stop tick", 32'(tick[3]), 0);
        check("t4 stop done", 32'(done[3]), 0);
        check("t4 stop busy", 32'(busy[3]), 0);
        cmd_op(3, 2'b01, 0);
        repeat (3) step();
        cmd_op(3, 2'b01, 0);
        check("t4 rst tick", 32'(tick[3]), 0);
        check("t4 rst done", 32'(done[3]), 0);
        wait_tick(3, n);
        check("t4 restart", n, 4);
        check("t4 done3", 32'(done[3]), 1);

        // 5: four channels running with P=3..6
        cmd_op(3, 2'b11, 0);
        clr = '1;
        step();
        clr = '0;
        for (int c = 0; c < 4; c++) cmd_op(c, 2'b00, 3 + c);
        for (int c = 0; c < 4; c++) begin
            cmd_op(c, 2'b01, 0);
            s[c] = cyc;
        end
        stopped = 1'b0;
        for (int i = 0; i < 30; i++) begin
            clr = (i >= 4 && i <= 6) ? 5'b00001 : 5'b00000;
            wr = 1'b0;
            if (i == 10) begin
                wr = 1'b1; sel = 3'd5; cmd = 2'b01;
            end else if (i == 12) begin
                wr = 1'b1; sel = 3'd0; cmd = 2'b00; wdata = 24'd3;
            end else if (i == 16) begin
                wr = 1'b1; sel = 3'd0; cmd = 2'b11;
                stopped = 1'b1;
            end
            step();
            e = cyc;
            for (int c = 0; c < 4; c++) begin
                d = e - s[c];
                exp_t[c] = (d > 0) && (d % (3 + c) == 0) &&
                           !(c == 0 && stopped);
            end
            check("t5 tick", 32'(tick[3:0]), 32'(exp_t));
            if (i >= 4 && i <= 6)
                check("t5 clr0", 32'(done[0]), 32'(exp_t[0]));
        end
        wr = 1'b0;
        clr = '0;
        check("t5 busy", 32'(busy), 32'(5'b01110));
        check("t5 ch4 done", 32'(done[4]), 0);

        // 6: async reset mid-count
        cmd_op(1, 2'b01, 0);
        step();
        rstn = 1'b0;
        #1;
        check("t6 tick", 32'(tick), 0);
        check("t6 busy", 32'(busy), 0);
        check("t6 done", 32'(done), 0);
        step();
        rstn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (tick != '0) cnt++;
        end
        check("t6 idle", cnt, 0);
        cmd_op(1, 2'b01, 0);
        wait_tick(1, n);
        check("t6 defp", n, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
